// File: rtl/tone_hist_stat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_hist_pkg
// Description : Shared types and constants for the tone_hist_stat block:
//               FSM state encoding, bin-index width helper, flush length.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_hist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Cycles spent in FLUSH so the last pixel clears the S1/S2 pipeline
    localparam int FLUSH_LEN = 2;

    // Number of data MSBs used as bin index (BIN_NUM is a power of 2, >= 2)
    function automatic int bin_idx_wth(input int bin_num);
        return $clog2(bin_num);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_hist_stat_if.sv
`default_nettype none
// ============================================================================
// Module      : tone_hist_stat_if
// Description : Pixel/frame stream, ROI/config registers and histogram
//               result bundle of tone_hist_stat.
//               master : stream source / register owner
//               slave  : the histogram block
// Revision    : 1.0 - initial release
// ============================================================================
interface tone_hist_stat_if #(
    parameter int COIW        = 8,
    parameter int COPW        = 0,
    parameter int BIN_NUM     = 16,
    parameter int BIN_CNT_WTH = 20,
    parameter int CNT_WTH     = 16
);
    localparam int DW = COIW + COPW;

    logic                           i_vstr;
    logic                           i_vend;
    logic                           i_hstr;
    logic                           i_href;
    logic                           i_hend;
    logic [DW-1:0]                  i_data;
    logic                           r_hist_en;
    logic [CNT_WTH-1:0]             r_roi_xstr;
    logic [CNT_WTH-1:0]             r_roi_xend;
    logic [CNT_WTH-1:0]             r_roi_ystr;
    logic [CNT_WTH-1:0]             r_roi_yend;
    logic [BIN_NUM*BIN_CNT_WTH-1:0] o_hist_data;
    logic                           o_hist_vld;
    logic [2*CNT_WTH-1:0]           o_pix_cnt;
    logic                           o_busy;

    modport master (
        output i_vstr, i_vend, i_hstr, i_href, i_hend, i_data,
        output r_hist_en, r_roi_xstr, r_roi_xend, r_roi_ystr, r_roi_yend,
        input  o_hist_data, o_hist_vld, o_pix_cnt, o_busy
    );

    modport slave (
        input  i_vstr, i_vend, i_hstr, i_href, i_hend, i_data,
        input  r_hist_en, r_roi_xstr, r_roi_xend, r_roi_ystr, r_roi_yend,
        output o_hist_data, o_hist_vld, o_pix_cnt, o_busy
    );

endinterface
`default_nettype wire

// File: rtl/tone_hist_stat_roi.sv
`default_nettype none
// ============================================================================
// Module      : tone_hist_roi
// Description : Pixel x / line y counters and ROI window compare.
// Ports       : clk, rst_n (sync, active low)
//               i_vstr/i_hstr/i_href/i_hend : frame and line markers
//               i_roi_*                     : inclusive ROI bounds
//               o_hit                       : current pixel lies in the ROI
// Revision    : 1.0 - initial release
// ============================================================================
module tone_hist_roi #(
    parameter int CNT_WTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_vstr,
    input  logic               i_hstr,
    input  logic               i_href,
    input  logic               i_hend,
    input  logic [CNT_WTH-1:0] i_roi_xstr,
    input  logic [CNT_WTH-1:0] i_roi_xend,
    input  logic [CNT_WTH-1:0] i_roi_ystr,
    input  logic [CNT_WTH-1:0] i_roi_yend,
    output logic               o_hit
);

    logic [CNT_WTH-1:0] r_x;
    logic [CNT_WTH-1:0] r_y;
    logic [CNT_WTH-1:0] w_x;
    logic [CNT_WTH-1:0] w_y;

    // The pixel presented with i_hstr is column 0; r_x already holds the
    // column of the next pixel.
    assign w_x = i_hstr ? '0 : r_x;
    assign w_y = i_vstr ? '0 : r_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (i_hstr)
                r_x <= i_href ? CNT_WTH'(1) : '0;
            else if (i_href)
                r_x <= r_x + CNT_WTH'(1);

            if (i_vstr)
                r_y <= '0;
            else if (i_hend)
                r_y <= r_y + CNT_WTH'(1);
        end
    end

    assign o_hit = i_href
                && (w_x >= i_roi_xstr) && (w_x <= i_roi_xend)
                && (w_y >= i_roi_ystr) && (w_y <= i_roi_yend);

endmodule
`default_nettype wire

// File: rtl/tone_hist_stat.sv
`default_nettype none
// ============================================================================
// Module      : tone_hist_stat
// Description : ROI luminance histogram of the tone-mapped stream, frozen and
//               published once per frame.
// Ports       : clk, rst_n (sync, active low)
//               bus (slave) : pixel stream, frame markers, enable, ROI bounds
//                             in; o_hist_data/o_hist_vld/o_pix_cnt/o_busy out
// Revision    : 1.0 - initial release
// ============================================================================
module tone_hist_stat
    import tone_hist_pkg::*;
#(
    parameter int COIW        = 8,
    parameter int COPW        = 0,
    parameter int BIN_NUM     = 16,
    parameter int BIN_CNT_WTH = 20,
    parameter int CNT_WTH     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    tone_hist_stat_if.slave  bus
);

    localparam int DW = COIW + COPW;
    localparam int IW = bin_idx_wth(BIN_NUM);
    localparam int PW = 2 * CNT_WTH;
    localparam int FW = 2;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [FW-1:0]                  r_flush_cnt;
    logic                           w_clear;
    logic                           w_publish;
    logic                           w_start;
    logic                           w_hit;
    logic                           r_vstr_dly;
    logic                           r_en_dly;
    logic                           r_s1_hit;
    logic [IW-1:0]                  r_s1_idx;
    logic [BIN_CNT_WTH-1:0]         r_bins [BIN_NUM];
    logic [PW-1:0]                  r_pix_cnt;
    logic [BIN_NUM*BIN_CNT_WTH-1:0] r_hist_data;
    logic [PW-1:0]                  r_hist_pix;
    logic                           r_hist_vld;

    tone_hist_roi #(
        .CNT_WTH (CNT_WTH)
    ) u_roi (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_vstr     (bus.i_vstr),
        .i_hstr     (bus.i_hstr),
        .i_href     (bus.i_href),
        .i_hend     (bus.i_hend),
        .i_roi_xstr (bus.r_roi_xstr),
        .i_roi_xend (bus.r_roi_xend),
        .i_roi_ystr (bus.r_roi_ystr),
        .i_roi_yend (bus.r_roi_yend),
        .o_hit      (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // A frame start seen during DONE is replayed from r_vstr_dly/r_en_dly
    // in the IDLE cycle that follows the publish.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_publish   = 1'b0;
        w_start     = (bus.i_vstr && bus.r_hist_en) || (r_vstr_dly && r_en_dly);
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                // A new frame start wins over a coincident frame end
                if (bus.i_vstr) begin
                    w_clear     = 1'b1;
                    w_state_nxt = bus.r_hist_en ? ST_ACC : ST_IDLE;
                end else if (bus.i_vend) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (bus.i_vstr) begin
                    w_clear     = 1'b1;
                    w_state_nxt = bus.r_hist_en ? ST_ACC : ST_IDLE;
                end else if (r_flush_cnt == FW'(FLUSH_LEN - 1)) begin
                    // Result registers load on DONE entry so data and the
                    // valid pulse are presented together in the DONE cycle
                    w_publish   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
            r_vstr_dly  <= 1'b0;
            r_en_dly    <= 1'b0;
            r_s1_hit    <= 1'b0;
            r_s1_idx    <= '0;
            r_pix_cnt   <= '0;
            r_hist_data <= '0;
            r_hist_pix  <= '0;
            r_hist_vld  <= 1'b0;
            for (int i = 0; i < BIN_NUM; i++)
                r_bins[i] <= '0;
        end else begin
            r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + FW'(1) : '0;
            r_vstr_dly  <= bus.i_vstr && (r_state == ST_DONE);
            r_en_dly    <= bus.r_hist_en;

            // S1: bin index and hit; a pixel coincident with a frame start
            // belongs to no accumulated frame
            r_s1_hit <= w_hit && (r_state == ST_ACC) && !bus.i_vstr;
            r_s1_idx <= bus.i_data[DW-1 -: IW];

            // S2: single-cycle read-modify-write, so consecutive hits on the
            // same bin always see the updated count
            if (w_clear) begin
                r_pix_cnt <= '0;
                for (int i = 0; i < BIN_NUM; i++)
                    r_bins[i] <= '0;
            end else if (r_s1_hit) begin
                if (r_bins[r_s1_idx] != '1)
                    r_bins[r_s1_idx] <= r_bins[r_s1_idx] + BIN_CNT_WTH'(1);
                if (r_pix_cnt != '1)
                    r_pix_cnt <= r_pix_cnt + PW'(1);
            end

            r_hist_vld <= w_publish;
            if (w_publish) begin
                r_hist_pix <= r_pix_cnt;
                for (int i = 0; i < BIN_NUM; i++)
                    r_hist_data[i*BIN_CNT_WTH +: BIN_CNT_WTH] <= r_bins[i];
            end
        end
    end

    assign bus.o_hist_data = r_hist_data;
    assign bus.o_hist_vld  = r_hist_vld;
    assign bus.o_pix_cnt   = r_hist_pix;
    assign bus.o_busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tone_hist_stat.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_hist_stat
// Description : Self-checking bench for tone_hist_stat. Two instances share
//               one stimulus stream: 20-bit bins (default) and 4-bit bins
//               (saturation). A frame-level model predicts every output on
//               every cycle; literal checks pin the key results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_hist_stat;

    localparam int BN = 16;
    localparam int WA = 20;
    localparam int WB = 4;
    localparam int CW = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vstr = 1'b0, vend = 1'b0, hstr = 1'b0, href = 1'b0, hend = 1'b0;
    logic        en   = 1'b0;
    logic [7:0]  data = '0;
    logic [15:0] xs = '0, xe = '0, ys = '0, ye = '0;
    int          px = 0, py = 0;

    int n_chk  = 0;
    int n_fail = 0;
    int n_vld  = 0;
    int cyc    = 0;
    int vend_cyc = -100;

    always #5 clk = ~clk;

    tone_hist_stat_if #(.BIN_CNT_WTH(WA), .CNT_WTH(CW)) bus_a ();
    tone_hist_stat_if #(.BIN_CNT_WTH(WB), .CNT_WTH(CW)) bus_b ();

    assign bus_a.i_vstr = vstr;   assign bus_b.i_vstr = vstr;
    assign bus_a.i_vend = vend;   assign bus_b.i_vend = vend;
    assign bus_a.i_hstr = hstr;   assign bus_b.i_hstr = hstr;
    assign bus_a.i_href = href;   assign bus_b.i_href = href;
    assign bus_a.i_hend = hend;   assign bus_b.i_hend = hend;
    assign bus_a.i_data = data;   assign bus_b.i_data = data;
    assign bus_a.r_hist_en  = en; assign bus_b.r_hist_en  = en;
    assign bus_a.r_roi_xstr = xs; assign bus_b.r_roi_xstr = xs;
    assign bus_a.r_roi_xend = xe; assign bus_b.r_roi_xend = xe;
    assign bus_a.r_roi_ystr = ys; assign bus_b.r_roi_ystr = ys;
    assign bus_a.r_roi_yend = ye; assign bus_b.r_roi_yend = ye;

    tone_hist_stat #(.BIN_CNT_WTH(WA), .CNT_WTH(CW)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    tone_hist_stat #(.BIN_CNT_WTH(WB), .CNT_WTH(CW)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // ---------------------------------------------------------------- model
    // Frame-level view: a frame collects ROI pixels from its start to its
    // end marker, then its result appears 3 cycles after the end marker for
    // one cycle and is held. acc[] counts unbounded; saturation is applied
    // per instance width at publish.
    int     acc [BN];
    int     pix;
    bit     collecting;
    int     cd;
    bit     pend;
    int     e_a [BN];
    int     e_b [BN];
    longint e_pix;
    bit     e_vld;
    bit     e_busy;

    function automatic bit in_roi();
        return href && (px >= int'(xs)) && (px <= int'(xe))
                    && (py >= int'(ys)) && (py <= int'(ye));
    endfunction

    always @(posedge clk) begin : model
        bit start_now;
        if (!rst_n) begin
            collecting = 0; cd = 0; pend = 0; pix = 0;
            e_vld = 0; e_busy = 0; e_pix = 0;
            for (int i = 0; i < BN; i++) begin
                acc[i] = 0; e_a[i] = 0; e_b[i] = 0;
            end
        end else begin
            start_now = (vstr && en) || pend;
            pend  = 0;
            e_vld = 0;
            if (cd > 0) begin
                if (vstr && cd >= 2) begin
                    for (int i = 0; i < BN; i++) acc[i] = 0;
                    pix = 0; cd = 0; collecting = en;
                end else begin
                    cd--;
                    if (cd == 1) begin
                        e_vld = 1;
                        e_pix = pix;
                        for (int i = 0; i < BN; i++) begin
                            e_a[i] = (acc[i] > (1 << WA) - 1) ? (1 << WA) - 1 : acc[i];
                            e_b[i] = (acc[i] > (1 << WB) - 1) ? (1 << WB) - 1 : acc[i];
                        end
                    end
                    if (cd == 0) pend = vstr && en;
                end
            end else if (collecting) begin
                if (vstr) begin
                    for (int i = 0; i < BN; i++) acc[i] = 0;
                    pix = 0; collecting = en;
                end else begin
                    if (in_roi()) begin
                        acc[data >> 4]++;
                        pix++;
                    end
                    if (vend) begin
                        cd = 3; collecting = 0;
                    end
                end
            end else if (start_now) begin
                for (int i = 0; i < BN; i++) acc[i] = 0;
                pix = 0; collecting = 1;
            end
            e_busy = collecting || (cd > 0);
        end
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------- compare
    initial begin : cmp
        logic [BN*WA-1:0] pa;
        logic [BN*WB-1:0] pb;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < BN; i++) begin
                pa[i*WA +: WA] = WA'(e_a[i]);
                pb[i*WB +: WB] = WB'(e_b[i]);
            end
            chk("a_hist_data", bus_a.o_hist_data, pa);
            chk("a_hist_vld",  bus_a.o_hist_vld,  e_vld);
            chk("a_pix_cnt",   bus_a.o_pix_cnt,   e_pix);
            chk("a_busy",      bus_a.o_busy,      e_busy);
            chk("b_hist_data", bus_b.o_hist_data, pb);
            chk("b_hist_vld",  bus_b.o_hist_vld,  e_vld);
            chk("b_pix_cnt",   bus_b.o_pix_cnt,   e_pix);
            chk("b_busy",      bus_b.o_busy,      e_busy);
            // Inputs seen now belong to cycle cyc, outputs to cycle cyc+1
            if (vend) vend_cyc = cyc;
            if (bus_a.o_hist_vld === 1'b1) begin
                n_vld++;
                chk("vld_latency", 32'(cyc + 1 - vend_cyc), 32'd3);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic frame(input int w, input int h, input int kind,
                         input logic [7:0] cval, input bit do_vend);
        @(negedge clk);
        vstr = 1; vend = 0; hstr = 0; href = 0; hend = 0;
        @(negedge clk);
        vstr = 0;
        repeat (2) @(negedge clk);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                @(negedge clk);
                hstr = (x == 0); href = 1; px = x; py = y;
                data = (kind == 0) ? 8'((y * w + x) % 256) : cval;
            end
            @(negedge clk);
            hstr = 0; href = 0; hend = 1;
            @(negedge clk);
            hend = 0;
            @(negedge clk);
        end
        if (do_vend) begin
            @(negedge clk); vend = 1;
            @(negedge clk); vend = 0;
        end
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [WA-1:0] bin_a(input int i);
        return bus_a.o_hist_data[i*WA +: WA];
    endfunction

    initial begin : main
        int v0;
        xs = 0; xe = 7; ys = 0; ye = 3; en = 1;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_hist_data", bus_a.o_hist_data, '0);
        chk("rst_hist_vld",  bus_a.o_hist_vld,  1'b0);
        chk("rst_pix_cnt",   bus_a.o_pix_cnt,   '0);
        chk("rst_busy",      bus_a.o_busy,      1'b0);
        rst_n = 1;
        @(negedge clk);

        // Ramp 0..31 over 8x4, full-frame ROI
        frame(8, 4, 0, 8'h00, 1);
        chk("ramp_bin0", bin_a(0), 16);
        chk("ramp_bin1", bin_a(1), 16);
        chk("ramp_bin2", bin_a(2), 0);
        chk("ramp_pix",  bus_a.o_pix_cnt, 32);
        chk("ramp_vld_count", n_vld, 1);

        // Constant 0xF3 over 16x8, ROI 4 columns x 2 lines
        xs = 2; xe = 5; ys = 1; ye = 2;
        frame(16, 8, 1, 8'hF3, 1);
        chk("roi_bin15", bin_a(15), 8);
        chk("roi_bin0",  bin_a(0), 0);
        chk("roi_pix",   bus_a.o_pix_cnt, 8);

        // 20 pixels into bin 3: 4-bit instance saturates at 15
        xs = 0; xe = 31; ys = 0; ye = 7;
        frame(20, 1, 1, 8'h30, 1);
        chk("sat_a_bin3", bin_a(3), 20);
        chk("sat_b_bin3", bus_b.o_hist_data[3*WB +: WB], 15);

        // Frame aborted by a new start, then a complete frame
        v0 = n_vld;
        frame(8, 2, 0, 8'h00, 0);
        frame(4, 2, 1, 8'h55, 1);
        chk("abort_vld_count", n_vld - v0, 1);
        chk("abort_bin5", bin_a(5), 8);
        chk("abort_bin0", bin_a(0), 0);
        chk("abort_pix",  bus_a.o_pix_cnt, 8);

        // Disabled frame is ignored, next enabled frame publishes
        v0 = n_vld;
        en = 0;
        frame(8, 4, 1, 8'hA0, 1);
        chk("dis_vld_count", n_vld - v0, 0);
        chk("dis_bin5_held", bin_a(5), 8);
        en = 1;
        frame(8, 4, 1, 8'hA0, 1);
        chk("en_bin10", bin_a(10), 32);
        chk("en_pix", bus_a.o_pix_cnt, 32);

        // Reset during accumulation, then a clean ramp frame
        frame(8, 2, 0, 8'h00, 0);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_hist_data", bus_a.o_hist_data, '0);
        chk("midrst_busy",      bus_a.o_busy,      1'b0);
        chk("midrst_pix",       bus_a.o_pix_cnt,   '0);
        rst_n = 1;
        @(negedge clk);
        frame(8, 4, 0, 8'h00, 1);
        chk("postrst_bin0", bin_a(0), 16);
        chk("postrst_bin1", bin_a(1), 16);

        // Empty ROI still publishes, all zero
        v0 = n_vld;
        xs = 5; xe = 4;
        frame(8, 4, 1, 8'h10, 1);
        chk("empty_vld_count", n_vld - v0, 1);
        chk("empty_hist", bus_a.o_hist_data, '0);
        chk("empty_pix",  bus_a.o_pix_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tone_hist_stat.md
# tone_hist_stat

Frame-statistics stage directly downstream of `tone_mapping`. It consumes the tone-mapped pixel stream (`o_hstr/o_href/o_hend/o_data`) together with the sensor frame markers (`vstr/vend`). It accumulates a `BIN_NUM`-bin luminance histogram over a programmable ROI and publishes the frozen histogram once per frame. Firmware uses the result to re-derive the `l_tone_y_data` curve for later frames.

## Interface
- `COIW`, default 8: integer width of pixel data.
- `COPW`, default 0: fractional width of pixel data. Data width `DW = COIW+COPW`.
- `BIN_NUM`, default 16: number of bins. Must be a power of 2 and at most `2^DW`.
- `BIN_CNT_WTH`, default 20: width of each bin counter.
- `CNT_WTH`, default 16: width of the x/y coordinate counters and the ROI registers.

Ports, clock and reset first:
- `clk` in 1: single clock; every flop is in this domain.
- `rst_n` in 1: synchronous, active-low reset, sampled on rising `clk`.
- `i_vstr` in 1: frame-start pulse.
- `i_vend` in 1: frame-end pulse.
- `i_hstr` in 1: line-start pulse; coincides with the first valid pixel of the line.
- `i_href` in 1: pixel valid.
- `i_hend` in 1: line-end pulse; asserts the cycle after the last pixel.
- `i_data` in `DW`: tone-mapped pixel.
- `r_hist_en` in 1: enables the statistics; sampled at `i_vstr` only.
- `r_roi_xstr`, `r_roi_xend` in `CNT_WTH`: inclusive pixel column bounds of the ROI.
- `r_roi_ystr`, `r_roi_yend` in `CNT_WTH`: inclusive line bounds of the ROI.
- `o_hist_data` out `BIN_NUM*BIN_CNT_WTH`: frozen histogram; bin 0 occupies the LSBs.
- `o_hist_vld` out 1: one-cycle pulse when `o_hist_data` updates.
- `o_pix_cnt` out `CNT_WTH+CNT_WTH`: count of ROI pixels in the frozen frame; saturates.
- `o_busy` out 1: high in all states except IDLE.

## Operation
- Bin index = top `log2(BIN_NUM)` bits of `i_data`.
- x counter:
  - Cleared to 0 on `i_hstr`.
  - Increments on every `i_href` cycle, so the pixel at `i_hstr` has x=0.
- y counter:
  - Cleared to 0 on `i_vstr`.
  - Increments on `i_hend`.
- ROI hit condition: `i_href` AND `xstr<=x<=xend` AND `ystr<=y<=yend`.
- State machine:
  - IDLE: on `i_vstr` with `r_hist_en`=1, clear all bins and `pix_cnt`, go to ACC. `i_vstr` with `r_hist_en`=0 is ignored.
  - ACC: each ROI hit increments its bin and `pix_cnt`. On `i_vend`, go to FLUSH.
  - FLUSH: 2 cycles to drain the pipeline, then go to DONE.
  - DONE: copy the bins to `o_hist_data` and `pix_cnt` to `o_pix_cnt`, pulse `o_hist_vld`, go to IDLE.
- Counter widths: bin counters and `pix_cnt` saturate at all-ones and never wrap.
- `i_vstr` while in ACC or FLUSH (missing `i_vend`): the frame is discarded, no `o_hist_vld` is issued, bins are cleared, and the state stays or re-enters ACC.
- `i_vstr` and `i_vend` asserted in the same cycle in ACC: `i_vend` is ignored and the frame restarts.
- `i_vstr` arriving in DONE: the current frame is published first, then the next cycle's IDLE transition applies. Both `i_vstr` and `r_hist_en` are registered one cycle so the start is not lost.
- ROI registers may change at any time; they take effect immediately, and firmware is responsible for consistency.
- An empty ROI (`xstr>xend` or `ystr>yend`) yields an all-zero histogram with a normal `o_hist_vld`.

## Timing
- Reset values: `o_hist_data`=0, `o_hist_vld`=0, `o_pix_cnt`=0, `o_busy`=0; state IDLE; internal bins 0.
- Pipeline:
  - S1 registers the bin index and the hit flag.
  - S2 does the read-modify-write of `bins[idx]`.
  - A pixel is counted 2 cycles after its `i_href`.
  - Back-to-back hits to the same bin must be counted exactly; the single-stage RMW makes this hazard-free.
- Publication latency: `o_hist_vld` asserts exactly 3 cycles after the `i_vend` cycle (2 FLUSH cycles plus DONE). `o_hist_data` is valid in that cycle and held until the next publish.
- Reset asserted mid-frame returns the block to the reset values on the next clock edge; the partial frame is lost.

## Structure
- `tone_hist_pkg` holds:
  - the state enum (IDLE/ACC/FLUSH/DONE);
  - the `BIN_IDX_WTH = $clog2(BIN_NUM)` function;
  - the FLUSH length constant (2).
- Sub-module `tone_hist_roi`: x/y counters plus the ROI compare, producing the hit flag. The top level contains the FSM, the bin array and the output latch.

## Test plan
- 8x4 frame, ROI full frame, `BIN_NUM`=16, data = 0x00..0xFF ramp modulo 256 -> bins 0 and 1 equal 16 each, others 0, `o_pix_cnt`=32, `o_hist_vld` 3 cycles after `i_vend`.
- 16x8 frame of constant 0xF3, ROI x=2..5, y=1..2 -> bin 15 = 8, all other bins 0, `o_pix_cnt`=8.
- `BIN_CNT_WTH`=4, 20 pixels into bin 3 -> bin 3 = 15, saturated, with no wrap.
- Second `i_vstr` mid-ACC without `i_vend` -> no `o_hist_vld` for the aborted frame; the next complete frame reports only its own pixels.
- `r_hist_en`=0 at `i_vstr` -> block stays IDLE, `o_busy`=0, `o_hist_data` unchanged. Setting `r_hist_en`=1 for the following frame -> normal publish.
- `rst_n` low for 1 cycle mid-ACC -> all outputs 0 on the next edge; the next full frame publishes correctly.
